// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the memory access sequencer.
package mem_access_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    // Request operation encoding as seen on req_op.
    typedef enum logic [1:0] {
        OP_LD   = 2'b00,
        OP_ST   = 2'b01,
        OP_SETB = 2'b10,
        OP_CLRB = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        READ   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the CPU datapath and the sequencer.
interface mem_access_unit_if #(
    parameter int unsigned DATA_WIDTH = mem_access_pkg::DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = mem_access_pkg::DEFAULT_ADDR_WIDTH
) ();
    import mem_access_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    op_t                   req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // CPU side: issues requests, consumes responses.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Sequencer side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_access_unit.sv
// Single-request sequencer in front of a one-cycle registered single-port RAM,
// supporting load, store and atomic bit set/clear via read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_unit_if.slave      bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    state_t                state_q,     state_d;
    op_t                   op_q,        op_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [BIT_W-1:0]      idx_q,       idx_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  ram_we_q,    ram_we_d;
    logic [DATA_WIDTH-1:0] ram_din_q,   ram_din_d;
    logic [DATA_WIDTH-1:0] bit_mask_c;
    logic                  req_ready_c;

    // Ready only in IDLE and never while reset is held.
    assign req_ready_c = rst_n && (state_q == IDLE);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we_d    = 1'b0;
        ram_din_d   = ram_din_q;
        bit_mask_c  = DATA_WIDTH'(1) << idx_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    idx_d   = bus.req_wdata[BIT_W-1:0];
                    state_d = ACCESS;
                    // Store data and strobe are set up so the write lands in ACCESS.
                    if (bus.req_op == OP_ST) begin
                        ram_we_d  = 1'b1;
                        ram_din_d = bus.req_wdata;
                    end
                end
            end
            ACCESS: begin
                if (op_q == OP_ST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                rdata_d = ram_dout;
                if (op_q == OP_LD) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ram_dout;
                    state_d     = RESP;
                end else begin
                    // Modified word is prepared here so it is on ram_din during WRITE.
                    ram_we_d  = 1'b1;
                    ram_din_d = (op_q == OP_SETB) ? (ram_dout | bit_mask_c)
                                                  : (ram_dout & ~bit_mask_c);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LD;
            addr_q      <= '0;
            idx_q       <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
        end
    end

    // Write strobe gated by reset so no write commits on a reset edge.
    assign ram_we        = ram_we_q & rst_n;
    assign ram_addr      = addr_q;
    assign ram_din       = ram_din_q;
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural single-port RAM.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Single-port RAM: write or registered read each cycle.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
    end

    typedef struct {
        op_t        op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency and write strobes, optionally stall the response.
    task automatic do_req(input op_t op, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic [7:0] exp_din,
                          input int stall, input string tag);
        int         n;
        int         we_cnt;
        int         we_first;
        int         exp_lat;
        int         exp_we;
        logic [7:0] din_seen;
        exp_lat = (op == OP_ST) ? 2 : (op == OP_LD) ? 3 : 4;
        exp_we  = (op == OP_ST) ? 1 : (op == OP_LD) ? 0 : 3;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_ready before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (stall == 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        n        = 1;
        we_cnt   = 0;
        we_first = 0;
        din_seen = 8'h00;
        while (n <= 20) begin
            if (ram_we) begin
                we_cnt++;
                if (we_first == 0) begin
                    we_first = n;
                    din_seen = ram_din;
                end
            end
            if (bus.rsp_valid) break;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
        check({tag, " we count"}, 32'(we_cnt), (exp_we != 0) ? 32'd1 : 32'd0);
        check({tag, " we cycle"}, 32'(we_first), 32'(exp_we));
        if (exp_we != 0) check({tag, " ram_din"}, 32'(din_seen), 32'(exp_din));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " stall rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
            check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, " stall ram_we"}, 32'(ram_we), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " rsp_valid after hs"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " req_ready after hs"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{OP_ST,   8'h10, 8'hA5, 8'h00, 8'hA5};
        vecs[1]  = '{OP_LD,   8'h10, 8'h00, 8'hA5, 8'h00};
        vecs[2]  = '{OP_SETB, 8'h10, 8'h01, 8'hA5, 8'hA7};
        vecs[3]  = '{OP_LD,   8'h10, 8'h00, 8'hA7, 8'h00};
        vecs[4]  = '{OP_CLRB, 8'h10, 8'h07, 8'hA7, 8'h27};
        vecs[5]  = '{OP_LD,   8'h10, 8'h00, 8'h27, 8'h00};
        vecs[6]  = '{OP_ST,   8'h30, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{OP_SETB, 8'h30, 8'hF9, 8'h00, 8'h02};
        vecs[8]  = '{OP_LD,   8'h30, 8'h00, 8'h02, 8'h00};
        vecs[9]  = '{OP_CLRB, 8'h30, 8'h09, 8'h02, 8'h00};
        vecs[10] = '{OP_LD,   8'h30, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{OP_ST,   8'h40, 8'hFF, 8'h00, 8'hFF};
        vecs[12] = '{OP_CLRB, 8'h40, 8'hF8, 8'hFF, 8'hFE};
        vecs[13] = '{OP_SETB, 8'h40, 8'h07, 8'hFE, 8'hFE};
        vecs[14] = '{OP_LD,   8'h40, 8'h00, 8'hFE, 8'h00};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LD;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("reset ram_we", 32'(ram_we), 32'd0);
        check("reset req_ready forced", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post reset req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   vecs[i].exp_din, 0, $sformatf("vec%0d", i));
        end

        do_req(OP_LD, 8'h10, 8'h00, 8'h27, 8'h00, 5, "stall ld");

        // Reset during the WRITE cycle of a SETB must leave memory untouched.
        do_req(OP_ST, 8'h20, 8'h00, 8'h00, 8'h00, 0, "pre st20");
        @(negedge clk);
        check("rmw req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SETB;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 8'h03;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmw write strobe", 32'(ram_we), 32'd1);
        check("rmw write data", 32'(ram_din), 32'h08);
        rst_n = 1'b0;
        #1;
        check("rmw we gated by reset", 32'(ram_we), 32'd0);
        check("rmw req_ready in reset", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rmw abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rmw abort req_ready", 32'(bus.req_ready), 32'd1);
        check("rmw abort mem", 32'(mem[8'h20]), 32'h00);
        do_req(OP_LD, 8'h20, 8'h00, 8'h00, 8'h00, 0, "ld20 after abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
